div_radix2: RTL



---
 rtl/div_radix2_pkg.sv | 13 +
 rtl/div_radix2.sv | 125 ++++++++++++
 2 files changed

// File: rtl/div_radix2_pkg.sv
// Shared types for the radix-2 restoring divider: handshake FSM states and default width.
package div_radix2_pkg;

  localparam int DIV_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_radix2.sv
// Multi-cycle restoring (radix-2) divider for DIV/DIVU, one quotient bit per cycle.
// Result packs {remainder, quotient} to match the HI/LO write path.
import div_radix2_pkg::*;

module div_radix2 #(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic             take_op;

  always_comb begin
    op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    op2_mag = op2_neg ? -opdata2_i : opdata2_i;
    take_op = (state == DIV_FREE) && start_i && !annul_i && (opdata2_i != '0);

    // Extra top bit on the trial keeps divisors near 2^WIDTH-1 from overflowing the compare.
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, dsr};
    q_bit    = ~trial[WIDTH+1];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {dvd[WIDTH-2:0], q_bit};
    quo_fix  = neg_q ? -quo_next : quo_next;
    rem_fix  = neg_r ? -rem_next : rem_next;
  end

  // NOTE: datapath registers carry no reset; the FSM reset alone guarantees they are reloaded before use.
  always_ff @(posedge clk) begin
    if (take_op) begin
      dvd   <= op1_mag;
      dsr   <= op2_mag;
      rem   <= '0;
      neg_q <= op1_neg ^ op2_neg;
      neg_r <= op1_neg;
    end else if (state == DIV_ON) begin
      dvd <= quo_next;
      rem <= rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            cnt   <= '0;
            state <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          state    <= DIV_END;
          ready_o  <= 1'b1;
          result_o <= '0;
        end
        DIV_ON: begin
          if (annul_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state    <= DIV_END;
              ready_o  <= 1'b1;
              result_o <= {rem_fix, quo_fix};
            end
          end
        end
        DIV_END: begin
          if (!start_i) begin
            state    <= DIV_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          state    <= DIV_FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule
